// File: rtl/p2s_scheduler_if.sv
// p2s_scheduler_if
//   Bundles the two channel req/ack/data handshakes with the serializer-side
//   signals (data word, load strobe, output_ready feedback).
//
//   Signals:
//     req_l/req_r     channel word ready
//     data_l/data_r   channel word, valid while req is high
//     ack_l/ack_r     combinational accept, word captured at this edge
//     p2s_data        word presented to the serializer
//     p2s_enable      one-cycle serializer load strobe
//     p2s_done        serializer output_ready
//
//   Modports:
//     master  channel accumulators + serializer side (drives req/data/done)
//     slave   the scheduler

interface p2s_scheduler_if #(
    parameter int WORD_BITS = 40
);
    logic                 req_l;
    logic                 req_r;
    logic [WORD_BITS-1:0] data_l;
    logic [WORD_BITS-1:0] data_r;
    logic                 ack_l;
    logic                 ack_r;
    logic [WORD_BITS-1:0] p2s_data;
    logic                 p2s_enable;
    logic                 p2s_done;

    modport master (
        output req_l, req_r, data_l, data_r, p2s_done,
        input  ack_l, ack_r, p2s_data, p2s_enable
    );

    modport slave (
        input  req_l, req_r, data_l, data_r, p2s_done,
        output ack_l, ack_r, p2s_data, p2s_enable
    );
endinterface

// File: rtl/p2s_scheduler.sv
// p2s_scheduler
//   Shares one parallel-to-serial output stage between the left and right
//   channel filter results. Each channel hands one word into its own holding
//   register; on every Frame pulse one pending word is picked round-robin,
//   loaded into the serializer, and the shift window is timed.
//
//   Ports:
//     Sclk        clock, rising edge
//     clear       synchronous active-high reset
//     Frame       one-cycle frame start pulse
//     bus         p2s_scheduler_if.slave (channel handshakes + serializer)
//     chan_sel    channel being serialized (0 = left, 1 = right)
//     busy        high in LOAD and SHIFT
//     frame_err   sticky, Frame seen while busy
//     sync_err    sticky, shift window ended without p2s_done
//     cnt_l/cnt_r words sent per channel
//
//   Optional build macro:
//     P2S_SCHED_STATS_EN  builds the per-channel word counters; otherwise
//                         cnt_l/cnt_r are tied to zero.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for a Frame with at least one held word
//   ST_LOAD  | one cycle, p2s_enable high, serializer takes p2s_data
//   ST_SHIFT | serializer shifting, down-counter times SHIFT_CYCLES

module p2s_scheduler #(
    parameter int WORD_BITS    = 40,
    parameter int SHIFT_CYCLES = 16
) (
    input  logic                 Sclk,
    input  logic                 clear,
    input  logic                 Frame,
    p2s_scheduler_if.slave       bus,
    output logic                 chan_sel,
    output logic                 busy,
    output logic                 frame_err,
    output logic                 sync_err,
    output logic [15:0]          cnt_l,
    output logic [15:0]          cnt_r
);

    localparam int CNT_W = (SHIFT_CYCLES > 1) ? $clog2(SHIFT_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nxt;

    logic                 hold_valid_l;
    logic                 hold_valid_r;
    logic [WORD_BITS-1:0] hold_data_l;
    logic [WORD_BITS-1:0] hold_data_r;
    logic [WORD_BITS-1:0] p2s_data_q;
    logic                 last_served;
    logic                 done_seen;
    logic [CNT_W-1:0]     shift_cnt;

    logic                 ack_l;
    logic                 ack_r;
    logic                 pick_r;
    logic                 start_load;
    logic                 shift_end;
    logic                 load_strobe;

    // Holding registers accept only when empty; no same-cycle bypass after LOAD.
    assign ack_l = bus.req_l & ~hold_valid_l & ~clear;
    assign ack_r = bus.req_r & ~hold_valid_r & ~clear;

    // Right wins when it is the only one pending, or both are pending and
    // left was served last.
    assign pick_r = hold_valid_r & (~hold_valid_l | ~last_served);

    assign bus.ack_l      = ack_l;
    assign bus.ack_r      = ack_r;
    assign bus.p2s_data   = p2s_data_q;
    assign bus.p2s_enable = load_strobe;

    always_ff @(posedge Sclk) begin
        if (clear) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        start_load  = 1'b0;
        shift_end   = 1'b0;
        load_strobe = 1'b0;
        busy        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (Frame && (hold_valid_l || hold_valid_r)) begin
                    start_load = 1'b1;
                    state_nxt  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                load_strobe = 1'b1;
                busy        = 1'b1;
                state_nxt   = ST_SHIFT;
            end
            ST_SHIFT: begin
                busy = 1'b1;
                if (shift_cnt == '0) begin
                    shift_end = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Sclk) begin
        if (clear) begin
            hold_valid_l <= 1'b0;
            hold_valid_r <= 1'b0;
            hold_data_l  <= '0;
            hold_data_r  <= '0;
            p2s_data_q   <= '0;
            chan_sel     <= 1'b0;
            last_served  <= 1'b1;
            done_seen    <= 1'b0;
            shift_cnt    <= '0;
            frame_err    <= 1'b0;
            sync_err     <= 1'b0;
        end else begin
            if (ack_l) begin
                hold_data_l  <= bus.data_l;
                hold_valid_l <= 1'b1;
            end else if (state == ST_LOAD && !chan_sel) begin
                hold_valid_l <= 1'b0;
            end

            if (ack_r) begin
                hold_data_r  <= bus.data_r;
                hold_valid_r <= 1'b1;
            end else if (state == ST_LOAD && chan_sel) begin
                hold_valid_r <= 1'b0;
            end

            // Word is latched on the way into LOAD so p2s_data holds it
            // for the whole LOAD cycle and afterwards.
            if (start_load) begin
                chan_sel    <= pick_r;
                last_served <= pick_r;
                p2s_data_q  <= pick_r ? hold_data_r : hold_data_l;
                done_seen   <= 1'b0;
            end

            if (state == ST_LOAD) begin
                shift_cnt <= CNT_W'(SHIFT_CYCLES - 1);
            end else if (state == ST_SHIFT && shift_cnt != '0) begin
                shift_cnt <= shift_cnt - CNT_W'(1);
            end

            if (state == ST_SHIFT && bus.p2s_done) begin
                done_seen <= 1'b1;
            end

            // p2s_done in the final cycle itself still counts.
            if (shift_end && !done_seen && !bus.p2s_done) begin
                sync_err <= 1'b1;
            end

            if (Frame && busy) begin
                frame_err <= 1'b1;
            end
        end
    end

`ifdef P2S_SCHED_STATS_EN
    always_ff @(posedge Sclk) begin
        if (clear) begin
            cnt_l <= '0;
            cnt_r <= '0;
        end else if (state == ST_LOAD) begin
            if (chan_sel) begin
                cnt_r <= cnt_r + 16'd1;
            end else begin
                cnt_l <= cnt_l + 16'd1;
            end
        end
    end
`else
    assign cnt_l = '0;
    assign cnt_r = '0;
`endif

endmodule

// File: doc/p2s_scheduler.md
# p2s_scheduler

Sequences the shared 40-bit parallel-to-serial output stage between the left- and right-channel filter results. Each channel hands over one finished word through a req/ack handshake into its own holding register. On each Frame pulse, the scheduler picks one pending word using round-robin, loads it into the serializer, and times the shift window. It sits between the channel accumulators and the serializer instance, and drives the serializer's data_in and p2s_enable.

## Interface
- WORD_BITS, 40: width of each channel word and of p2s_data.
- SHIFT_CYCLES, 16: number of Sclk cycles the serializer needs to shift one word after load.
- Sclk  in  1  single clock; all logic on its rising edge.
- clear  in  1  reset; synchronous, active-high.
- Frame  in  1  one-cycle pulse marking the start of an output frame.
- req_l / req_r  in  1  channel has a word ready.
- data_l / data_r  in  WORD_BITS  channel word; valid while req is high.
- ack_l / ack_r  out  1  combinational; word is captured at this edge.
- p2s_data  out  WORD_BITS  word presented to the serializer.
- p2s_enable  out  1  one-cycle serializer load strobe.
- p2s_done  in  1  serializer's output_ready, sampled during the shift window.
- chan_sel  out  1  0 = left, 1 = right; the channel being serialized.
- busy  out  1  high in LOAD and SHIFT.
- frame_err  out  1  sticky; a Frame arrived while busy.
- sync_err  out  1  sticky; a shift window ended without p2s_done.
- cnt_l / cnt_r  out  16  words sent per channel (see Configuration).

## Operation
- Holding registers:
  - ack_x = req_x & ~hold_valid_x.
  - When ack_x is high, data_x is captured at the edge and hold_valid_x is set.
  - There is no bypass: a register freed by LOAD in a cycle cannot accept in that same cycle.
- FSM states: IDLE, LOAD, SHIFT.
- IDLE:
  - Frame=1 with at least one hold_valid → LOAD.
  - Frame=1 with none valid → stay in IDLE; nothing is loaded.
- Arbitration at the Frame edge:
  - Only one channel valid → that channel.
  - Both valid → the channel opposite last_served.
  - last_served resets to right, so left wins first after reset.
  - chan_sel and last_served update at the transition into LOAD.
- LOAD (1 cycle):
  - p2s_enable=1; p2s_data = held word of chan_sel.
  - The hold_valid for chan_sel clears at the end of the cycle.
  - Counter loads SHIFT_CYCLES-1; next state → SHIFT.
- SHIFT:
  - Counter decrements each cycle.
  - p2s_done=1 on any SHIFT cycle sets done_seen.
  - Counter at 0 → IDLE. If done_seen is 0 and p2s_done is 0 in that cycle, set sync_err.
  - done_seen is cleared on entry to LOAD.
- Frame while in LOAD or SHIFT: ignored, frame_err set, the FSM continues unaffected.
- p2s_data keeps its value outside LOAD.
- chan_sel keeps its last value in IDLE.

## Timing
- Reset values: p2s_enable 0, p2s_data 0, chan_sel 0, busy 0, frame_err 0, sync_err 0, cnt_l/cnt_r 0, holding registers empty, FSM IDLE, last_served = right.
- ack is combinational, so ack_x=0 whenever clear=1 or req_x=0.
- Frame at cycle t in IDLE with a valid word:
  - p2s_enable=1 at cycle t+1.
  - SHIFT covers t+2 .. t+1+SHIFT_CYCLES.
  - IDLE at t+2+SHIFT_CYCLES; the earliest next accepted Frame is at that cycle.
- A channel may re-request in the cycle after its LOAD (hold_valid is clear by then).
- A Frame in the same cycle the FSM returns to IDLE is accepted normally.
- clear asserted mid-LOAD or mid-SHIFT:
  - At the next edge: FSM → IDLE, holds emptied, flags and counters zeroed.
  - p2s_enable is 0 from that cycle on.
  - Any partially shifted word is abandoned.
- A req and a Frame in the same cycle with that channel empty: capture happens at the edge, but arbitration sees the pre-edge hold_valid. The word waits for the next Frame.

## Configuration
- P2S_SCHED_STATS_EN defined:
  - cnt_l/cnt_r increment (16-bit, wrapping 0xFFFF→0) on each LOAD of their channel.
  - clear zeros them.
- Not defined: cnt_l/cnt_r are tied to 0 and no counter logic is built.

## Test plan
- Reset, then req_l with data_l=40'h12_3456_789A, then Frame → ack_l same cycle as req; p2s_enable one cycle later with p2s_data=40'h12_3456_789A and chan_sel=0; busy for 1+16 cycles.
- Both channels loaded (L=40'hAA..., R=40'h55...), four Frames spaced 20 cycles apart → serve order L, R, L only if refilled, otherwise R alone. Check alternation when both are always refilled.
- Frame at cycle 5 of SHIFT → frame_err=1; no second p2s_enable; return to IDLE on schedule.
- p2s_done held at 0 throughout a window → sync_err=1 on exit from SHIFT. Pulsing p2s_done at SHIFT cycle 15 → sync_err stays 0.
- req_l held high while hold_l is full → ack_l=0 until the cycle after hold_l's LOAD, then ack_l=1 and the new word is captured.
- clear at SHIFT cycle 7 → next cycle busy=0, p2s_enable=0, errors=0, holds empty; with P2S_SCHED_STATS_EN, cnt_l returns to 0 after reaching 3.
